// File: rtl/rv32_encoder.sv
// rv32_encoder: builds RV32I instruction words from field-level requests and
// streams them, with incrementing addresses, into an instruction-memory loader.
// The LI pseudo-instruction expands to ADDI, LUI, or LUI followed by ADDI.
module rv32_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              restart,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_STORE  = 7'h23;

    typedef enum logic {S_IDLE, S_LI_LO} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [31:0]       r_lo_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic              w_accept, w_hs;
    logic              w_legal, w_two;
    logic [31:0]       w_instr, w_lo;
    logic              w_fit12, w_fit13, w_fit21, w_shamt_ok, w_is_shift;
    logic [19:0]       w_li_hi;

    // Immediate range classification
    assign w_fit12    = (req_imm[31:11] == {21{req_imm[11]}});
    assign w_fit13    = (req_imm[31:12] == {20{req_imm[12]}});
    assign w_fit21    = (req_imm[31:20] == {12{req_imm[20]}});
    assign w_shamt_ok = (req_imm[31:5] == 27'd0);
    assign w_is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    // (imm + 0x800) >> 12 folded so that the low 12 bits never need an adder
    assign w_li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};

    assign w_hs      = r_out_valid & out_ready;
    assign req_ready = (r_state == S_IDLE) & (~r_out_valid | out_ready) & ~restart;
    assign w_accept  = req_valid & req_ready;

    // Field-level request -> instruction word plus legality
    always_comb begin
        w_legal = 1'b0;
        w_two   = 1'b0;
        w_instr = '0;
        w_lo    = '0;
        case (req_kind)
            4'd0: begin
                w_legal = (req_imm[11:0] == 12'd0);
                w_instr = {req_imm[31:12], req_rd, OPC_LUI};
            end
            4'd1: begin
                w_legal = (req_imm[11:0] == 12'd0);
                w_instr = {req_imm[31:12], req_rd, OPC_AUIPC};
            end
            4'd2: begin
                w_legal = w_fit21 & ~req_imm[0];
                w_instr = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                           req_rd, OPC_JAL};
            end
            4'd3: begin
                w_legal = w_fit12;
                w_instr = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
            end
            4'd4: begin
                w_legal = w_fit13 & ~req_imm[0] &
                          (req_funct3 != 3'b010) & (req_funct3 != 3'b011);
                w_instr = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                           req_imm[4:1], req_imm[11], OPC_BRANCH};
            end
            4'd5: begin
                if (w_is_shift) begin
                    w_legal = w_shamt_ok;
                    w_instr = {1'b0, req_alt, 5'b0, req_imm[4:0], req_rs1, req_funct3,
                               req_rd, OPC_OPIMM};
                end else begin
                    w_legal = w_fit12;
                    w_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OPIMM};
                end
            end
            4'd6: begin
                w_legal = 1'b1;
                w_instr = {1'b0, req_alt, 5'b0, req_rs2, req_rs1, req_funct3,
                           req_rd, OPC_OP};
            end
            4'd7: begin
                w_legal = w_fit12;
                w_instr = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0],
                           OPC_STORE};
            end
            4'd8: begin
                w_legal = 1'b1;
                if (w_fit12) begin
                    w_instr = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OPIMM};
                end else begin
                    w_instr = {w_li_hi, req_rd, OPC_LUI};
                    w_two   = (req_imm[11:0] != 12'd0);
                    w_lo    = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_OPIMM};
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // LI expansion state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state: enter LI_LO on a two-word LI, leave once the LUI is taken
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_legal && w_two) w_state_nxt = S_LI_LO;
                S_LI_LO: if (w_hs) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output word, address counter and error pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_lo_instr  <= '0;
            r_addr      <= BASE_ADDR;
            r_err       <= 1'b0;
        end else if (restart) begin
            r_out_valid <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_legal;
            if (w_hs) r_addr <= r_addr + ADDR_W'(4);
            if (r_state == S_LI_LO) begin
                // LUI is on the output; the ADDI replaces it once taken
                if (w_hs) r_out_instr <= r_lo_instr;
            end else if (w_accept && w_legal) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                if (w_two) r_lo_instr <= w_lo;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_addr;
    assign err       = r_err;

endmodule

// File: tb/tb_rv32_encoder.sv
// Self-checking bench for rv32_encoder: directed spec cases plus a randomized
// run checked against an instruction-level reference model and word queue.
module tb_rv32_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        resetn, restart, req_valid, req_ready, req_alt;
    logic [3:0]  req_kind;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        out_valid, out_ready, err;
    logic [31:0] out_instr, out_addr;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr;
    logic [31:0] q[$];

    rv32_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn), .restart(restart),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_funct3(req_funct3), .req_alt(req_alt), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic bit fits(input longint s, input int bits);
        return (s >= -(longint'(1) << (bits - 1))) && (s < (longint'(1) << (bits - 1)));
    endfunction

    // Reference: what words (0, 1 or 2) a request must produce
    function automatic void ref_enc(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] imm,
                                    output bit ok, output int n,
                                    output logic [31:0] w0, output logic [31:0] w1);
        longint s;
        logic [31:0] d, a, b, f, hi, lo, op;
        s  = longint'($signed(imm));
        d  = 32'(rd) << 7;
        a  = 32'(rs1) << 15;
        b  = 32'(rs2) << 20;
        f  = 32'(f3) << 12;
        ok = 1'b1; n = 1; w0 = '0; w1 = '0;
        case (k)
            4'd0, 4'd1: begin
                op = (k == 4'd0) ? 32'h37 : 32'h17;
                ok = (imm % 4096) == 0;
                w0 = imm | d | op;
            end
            4'd2: begin
                ok = fits(s, 21) && (imm % 2 == 0);
                w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                     (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
            end
            4'd3: begin
                ok = fits(s, 12);
                w0 = ((imm & 32'hFFF) << 20) | a | d | 32'h67;
            end
            4'd4: begin
                ok = fits(s, 13) && (imm % 2 == 0) && f3 != 3'd2 && f3 != 3'd3;
                w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | b | a | f |
                     (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            end
            4'd5: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (s >= 0) && (s < 32);
                    w0 = (32'(alt) << 30) | ((imm & 32'h1F) << 20) | a | f | d | 32'h13;
                end else begin
                    ok = fits(s, 12);
                    w0 = ((imm & 32'hFFF) << 20) | a | f | d | 32'h13;
                end
            end
            4'd6: w0 = (32'(alt) << 30) | b | a | f | d | 32'h33;
            4'd7: begin
                ok = fits(s, 12);
                w0 = (((imm >> 5) & 32'h7F) << 25) | b | a | f | ((imm & 32'h1F) << 7) | 32'h23;
            end
            4'd8: begin
                if (fits(s, 12)) begin
                    w0 = ((imm & 32'hFFF) << 20) | d | 32'h13;
                end else begin
                    hi = (imm + 32'd2048) >> 12;
                    lo = imm & 32'hFFF;
                    w0 = (hi << 12) | d | 32'h37;
                    if (lo != 0) begin
                        n  = 2;
                        w1 = (lo << 20) | (32'(rd) << 15) | d | 32'h13;
                    end
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) n = 0;
    endfunction

    task automatic set_req(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        req_kind = k; req_funct3 = f3; req_alt = alt;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; restart = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        set_req(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_instr !== 32'd0) begin bad++; $display("FAIL rst_instr: got %h want 0", out_instr); end
        total++; if (out_addr !== BASE) begin bad++; $display("FAIL rst_addr: got %h want %h", out_addr, BASE); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        resetn = 1'b1;
        exp_addr = BASE;
    endtask

    task automatic test_examples();
        logic [3:0]  k[4]   = '{4'd5, 4'd5, 4'd7, 4'd4};
        logic [2:0]  f3[4]  = '{3'd0, 3'd5, 3'd2, 3'd0};
        logic        al[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0]  rd[4]  = '{5'd1, 5'd1, 5'd0, 5'd0};
        logic [4:0]  r1[4]  = '{5'd0, 5'd1, 5'd2, 5'd1};
        logic [4:0]  r2[4]  = '{5'd0, 5'd0, 5'd5, 5'd2};
        logic [31:0] im[4]  = '{32'd5, 32'd3, 32'd8, 32'd8};
        logic [31:0] ex[4]  = '{32'h00500093, 32'h4030D093, 32'h00512423, 32'h00208463};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_req(k[i], f3[i], al[i], rd[i], r1[i], r2[i], im[i]);
            out_ready = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ex_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (out_instr !== ex[i]) begin bad++; $display("FAIL ex_instr[%0d]: got %h want %h", i, out_instr, ex[i]); end
            total++; if (out_addr !== exp_addr) begin bad++; $display("FAIL ex_addr[%0d]: got %h want %h", i, out_addr, exp_addr); end
            exp_addr = exp_addr + 32'd4;
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ex_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_err();
        logic [3:0]  k[4]  = '{4'd4, 4'd12, 4'd4, 4'd5};
        logic [2:0]  f3[4] = '{3'd0, 3'd0, 3'd2, 3'd1};
        logic [31:0] im[4] = '{32'd7, 32'd0, 32'd8, 32'd32};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_req(k[i], f3[i], 1'b0, 5'd1, 5'd1, 5'd2, im[i]);
            out_ready = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            total++; if (err !== 1'b1) begin bad++; $display("FAIL err_pulse[%0d]: got %b want 1", i, err); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL err_novalid[%0d]: got %b want 0", i, out_valid); end
            total++; if (out_addr !== exp_addr) begin bad++; $display("FAIL err_addr[%0d]: got %h want %h", i, out_addr, exp_addr); end
            @(negedge clk);
            total++; if (err !== 1'b0) begin bad++; $display("FAIL err_one[%0d]: got %b want 0", i, err); end
        end
    endtask

    task automatic test_li();
        @(negedge clk);
        set_req(4'd8, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h12345FFF);
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        // address has wrapped past 2^32 by now
        total++; if (out_addr !== 32'd0) begin bad++; $display("FAIL li_wrap: got %h want 0", out_addr); end
        total++; if (out_instr !== 32'h123461B7) begin bad++; $display("FAIL li_lui: got %h want 123461b7", out_instr); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL li_ready: got %b want 0", req_ready); end
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL li_v2: got %b want 1", out_valid); end
        total++; if (out_instr !== 32'hFFF18193) begin bad++; $display("FAIL li_addi: got %h want fff18193", out_instr); end
        total++; if (out_addr !== exp_addr) begin bad++; $display("FAIL li_addr2: got %h want %h", out_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL li_done: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        bit ok; int n;
        logic [31:0] wa, wb, wc, wx;
        ref_enc(4'd6, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0, ok, n, wa, wx);
        ref_enc(4'd5, 3'd0, 1'b0, 5'd9, 5'd9, 5'd0, 32'hFFFFFFFF, ok, n, wb, wx);
        ref_enc(4'd0, 3'd0, 1'b0, 5'd31, 5'd0, 5'd0, 32'hABCDE000, ok, n, wc, wx);
        @(negedge clk);
        set_req(4'd6, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        set_req(4'd5, 3'd0, 1'b0, 5'd9, 5'd9, 5'd0, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (out_instr !== wa || out_valid !== 1'b1) begin bad++; $display("FAIL stall_instr[%0d]: got %h/%b want %h/1", i, out_instr, out_valid, wa); end
            total++; if (out_addr !== exp_addr) begin bad++; $display("FAIL stall_addr[%0d]: got %h want %h", i, out_addr, exp_addr); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, req_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        set_req(4'd0, 3'd0, 1'b0, 5'd31, 5'd0, 5'd0, 32'hABCDE000);
        total++; if (out_instr !== wb || out_addr !== exp_addr) begin bad++; $display("FAIL b2b_w1: got %h@%h want %h@%h", out_instr, out_addr, wb, exp_addr); end
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (out_instr !== wc || out_addr !== exp_addr) begin bad++; $display("FAIL b2b_w2: got %h@%h want %h@%h", out_instr, out_addr, wc, exp_addr); end
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_restart();
        bit ok; int n;
        logic [31:0] w, wx;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                ref_enc(4'd6, 3'(i - 1), 1'b0, 5'(i), 5'd2, 5'd3, 32'd0, ok, n, w, wx);
                total++; if (out_instr !== w || out_addr !== exp_addr) begin bad++; $display("FAIL rs_w[%0d]: got %h@%h want %h@%h", i - 1, out_instr, out_addr, w, exp_addr); end
                exp_addr = exp_addr + 32'd4;
            end
            set_req(4'd6, 3'(i), 1'b0, 5'(i + 1), 5'd2, 5'd3, 32'd0);
        end
        @(negedge clk);
        // third word is shown; restart now with a request that must be dropped
        set_req(4'd6, 3'd7, 1'b0, 5'd20, 5'd2, 5'd3, 32'd0);
        restart = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rs_ready: got %b want 0", req_ready); end
        @(negedge clk);
        restart = 1'b0; req_valid = 1'b0;
        exp_addr = BASE;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_valid: got %b want 0", out_valid); end
        total++; if (out_addr !== BASE) begin bad++; $display("FAIL rs_addr: got %h want %h", out_addr, BASE); end
        set_req(4'd3, 3'd0, 1'b0, 5'd1, 5'd4, 5'd0, 32'hFFFFF800);
        ref_enc(4'd3, 3'd0, 1'b0, 5'd1, 5'd4, 5'd0, 32'hFFFFF800, ok, n, w, wx);
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (out_instr !== w || out_addr !== BASE) begin bad++; $display("FAIL rs_next: got %h@%h want %h@%h", out_instr, out_addr, w, BASE); end
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_li();
        @(negedge clk);
        set_req(4'd8, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h7FFFF800);
        out_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (out_instr !== 32'h800003B7) begin bad++; $display("FAIL mid_lui: got %h want 800003b7", out_instr); end
        #2 resetn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== BASE) begin bad++; $display("FAIL mid_rst: got %b %h %h want 0 0 %h", out_valid, out_instr, out_addr, BASE); end
        @(negedge clk);
        resetn = 1'b1; out_ready = 1'b1;
        exp_addr = BASE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_idle[%0d]: got v=%b rdy=%b want v=0 rdy=1", i, out_valid, req_ready); end
        end
    endtask

    task automatic test_random();
        bit ok; int n;
        logic [31:0] w0, w1, imm;
        bit err_exp = 1'b0;
        bit rdy_exp;
        logic [3:0] k;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if (out_instr !== q[0] || out_addr !== exp_addr) begin bad++; $display("FAIL rnd_word@%0d: got %h@%h want %h@%h", c, out_instr, out_addr, q[0], exp_addr); end
            end
            total++; if (err !== err_exp) begin bad++; $display("FAIL rnd_err@%0d: got %b want %b", c, err, err_exp); end
            restart   = ($urandom % 60) == 0;
            out_ready = ($urandom % 10) < 7;
            k = (($urandom % 10) == 0) ? 4'(9 + $urandom % 7) : 4'($urandom % 9);
            case ($urandom % 4)
                0: imm = 32'($urandom % 64) - 32'd24;
                1: imm = $urandom;
                2: imm = $urandom & 32'hFFFFF000;
                default: imm = (32'($urandom % 8192) - 32'd4096) & ~32'(($urandom % 4) != 0);
            endcase
            set_req(k, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            req_valid = ($urandom % 4) != 0;
            #1;
            rdy_exp = !restart && (q.size() == 0 || (q.size() == 1 && out_ready));
            total++; if (req_ready !== rdy_exp) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready, rdy_exp); end
            if (restart) begin
                q.delete();
                exp_addr = BASE;
                err_exp  = 1'b0;
            end else begin
                if (q.size() != 0 && out_ready) begin
                    void'(q.pop_front());
                    exp_addr = exp_addr + 32'd4;
                end
                err_exp = 1'b0;
                if (req_valid && rdy_exp) begin
                    ref_enc(req_kind, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm, ok, n, w0, w1);
                    err_exp = !ok;
                    if (n >= 1) q.push_back(w0);
                    if (n == 2) q.push_back(w1);
                end
            end
        end
        @(negedge clk);
        req_valid = 1'b0; restart = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            #1;
            total++; if (out_instr !== q[0] || out_addr !== exp_addr) begin bad++; $display("FAIL drain_word@%0d: got %h@%h want %h@%h", c, out_instr, out_addr, q[0], exp_addr); end
            void'(q.pop_front());
            exp_addr = exp_addr + 32'd4;
            @(negedge clk);
        end
        total++; if (q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_end: got v=%b left=%0d want v=0 left=0", out_valid, q.size()); end
    endtask

    initial begin
        test_reset();
        test_examples();
        test_err();
        test_li();
        test_back_to_back();
        test_restart();
        test_reset_mid_li();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
